ni_flit_receiver: RTL
=====================

NI_FLIT_RECEIVER -- requirements
Module: ni_flit_receiver

Interface
REQ-001 SHALL have parameter X_NODE_NUM, default 4: mesh columns; X_W = log2(X_NODE_NUM).
REQ-002 SHALL have parameter Y_NODE_NUM, default 3: mesh rows; Y_W = log2(Y_NODE_NUM).
REQ-003 SHALL have parameter SW_X_ADDR, default 2: own X address.
REQ-004 SHALL have parameter SW_Y_ADDR, default 1: own Y address.
REQ-005 SHALL have parameter FLIT_WIDTH, default 32: flit payload bits.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two: receive buffer depth = credits granted upstream.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port flit_in  input  FLIT_WIDTH+2  bit FLIT_WIDTH+1 = head, bit FLIT_WIDTH = tail, rest payload.
REQ-010 SHALL have port flit_wr_in  input  1  flit valid from router local port.
REQ-011 SHALL have port credit_out  output  1  one-cycle pulse per freed buffer slot.
REQ-012 SHALL have port pck_data_out  output  FLIT_WIDTH  buffered flit payload to core.
REQ-013 SHALL have ports pck_sop_out / pck_eop_out  output  1 each  head / tail flag of pck_data_out.
REQ-014 SHALL have port pck_valid_out  output  1  buffer non-empty.
REQ-015 SHALL have port pck_ready_in  input  1  core accepts; pop when valid&ready.
REQ-016 SHALL have ports src_x_out / src_y_out  output  X_W / Y_W  source address of current packet.
REQ-017 SHALL have ports addr_err_out / proto_err_out / ovf_err_out  output  1 each  sticky error flags.

Function
REQ-018 Header flit fields SHALL be: dest_y = payload[Y_W-1:0], dest_x = [Y_W+X_W-1:Y_W], src_y = [2Y_W+X_W-1:Y_W+X_W], src_x = [2Y_W+2X_W-1:2Y_W+X_W].
REQ-019 FSM SHALL have states IDLE, RECV, DROP; reset state IDLE.
REQ-020 IDLE + head with matching dest: write flit, latch src_x/src_y, go RECV (stay IDLE if tail also set).
REQ-021 IDLE + head with dest != (SW_X_ADDR,SW_Y_ADDR): discard, set addr_err_out, go DROP (stay IDLE if tail set).
REQ-022 RECV: write every flit; tail returns to IDLE.
REQ-023 DROP: discard every flit; tail returns to IDLE.
REQ-024 Non-head flit in IDLE: discard, set proto_err_out, stay IDLE.
REQ-025 Head flit in RECV or DROP: set proto_err_out, then process as in IDLE (new packet).
REQ-026 Write accepted at edge N SHALL appear on pck_valid_out/pck_data_out after edge N (first-word fall-through, 1-cycle latency).
REQ-027 Each pop and each discarded flit SHALL produce exactly one credit_out pulse in the following cycle; pop and discard in same cycle SHALL produce two pulses on consecutive cycles (2-entry credit counter, never lost).
REQ-028 Write while FIFO full (even with same-cycle pop): flit dropped, ovf_err_out set, no credit returned.
REQ-029 Empty FIFO: pck_valid_out = 0, pop ignored; pointers wrap modulo FIFO_DEPTH.
REQ-030 src_x_out/src_y_out SHALL hold until next accepted head.

Reset
REQ-031 reset SHALL asynchronously clear FSM to IDLE, FIFO pointers/count to 0, pending credits to 0, all error flags, src_x_out, src_y_out, credit_out, pck_valid_out to 0.
REQ-032 Reset mid-packet SHALL drop in-flight and buffered flits without issuing credits for them.

Configuration
REQ-033 With macro NI_RX_ADDR_CHECK_EN defined: REQ-021 address check active.
REQ-034 Without NI_RX_ADDR_CHECK_EN: every head accepted as matching, DROP unreachable, addr_err_out tied 0.

Verification
REQ-035 Head dest (2,1) src (0,2), 2 body, tail, ready=1 -> 4 flits out in order, sop on first, eop on last, src_out=(0,2), 4 credit pulses.
REQ-036 Head dest (3,1) + tail (ADDR_CHECK_EN) -> no pck_valid_out, addr_err_out=1, 2 credit pulses.
REQ-037 ready=0, 5 flits written -> 5th dropped, ovf_err_out=1, pck_valid_out stays 1, 4 flits later drained with 4 credits.
REQ-038 Body flit in IDLE -> discarded, proto_err_out=1, one credit pulse.
REQ-039 Pop and discard in same cycle -> credit_out high two consecutive cycles.
REQ-040 reset asserted after head+1 body buffered -> all outputs 0 immediately, no credits, next packet received normally.

Source files
------------

// File: rtl/ni_flit_receiver_if.sv
// Network-interface receive port bundle: router local-port flits in,
// credits back to the router, buffered packet stream out to the core.
// The receiver uses the slave modport; the router/core side uses master.
interface ni_flit_receiver_if #(
   parameter int FLIT_WIDTH = 32,
   parameter int X_W        = 2,
   parameter int Y_W        = 2
);
   logic [FLIT_WIDTH+1:0] flit_in;
   logic                  flit_wr_in;
   logic                  credit_out;
   logic [FLIT_WIDTH-1:0] pck_data_out;
   logic                  pck_sop_out;
   logic                  pck_eop_out;
   logic                  pck_valid_out;
   logic                  pck_ready_in;
   logic [X_W-1:0]        src_x_out;
   logic [Y_W-1:0]        src_y_out;
   logic                  addr_err_out;
   logic                  proto_err_out;
   logic                  ovf_err_out;

   modport slave (
      input  flit_in, flit_wr_in, pck_ready_in,
      output credit_out, pck_data_out, pck_sop_out, pck_eop_out, pck_valid_out,
      output src_x_out, src_y_out, addr_err_out, proto_err_out, ovf_err_out
   );

   modport master (
      output flit_in, flit_wr_in, pck_ready_in,
      input  credit_out, pck_data_out, pck_sop_out, pck_eop_out, pck_valid_out,
      input  src_x_out, src_y_out, addr_err_out, proto_err_out, ovf_err_out
   );
endinterface

// File: rtl/ni_flit_receiver.sv
// Flit receiver of a mesh network interface. Classifies incoming flits
// (head/body/tail), buffers flits of packets addressed to this node in a
// first-word fall-through FIFO, and returns one credit per freed slot.
// Optional feature: define NI_RX_ADDR_CHECK_EN to discard packets whose
// header destination differs from (SW_X_ADDR, SW_Y_ADDR); without it every
// head is accepted and addr_err_out is tied low.
module ni_flit_receiver #(
   parameter int X_NODE_NUM = 4,
   parameter int Y_NODE_NUM = 3,
   parameter int SW_X_ADDR  = 2,
   parameter int SW_Y_ADDR  = 1,
   parameter int FLIT_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input logic               clk,
   input logic               reset,
   ni_flit_receiver_if.slave rx
);
   localparam int X_W = $clog2(X_NODE_NUM);
   localparam int Y_W = $clog2(Y_NODE_NUM);
   localparam int AW  = $clog2(FIFO_DEPTH);
   // Pending-credit counter is sized so no credit can ever be lost
   localparam int CW  = $clog2(FIFO_DEPTH + 2) + 1;
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [X_W-1:0] OWN_X    = X_W'(SW_X_ADDR);
   localparam logic [Y_W-1:0] OWN_Y    = Y_W'(SW_Y_ADDR);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t                state_r, next_state_s;
   logic                  flit_head_s, flit_tail_s;
   logic [X_W-1:0]        hdr_dest_x_s, hdr_src_x_s;
   logic [Y_W-1:0]        hdr_dest_y_s, hdr_src_y_s;
   logic                  hdr_match_s, dest_match_s;
   logic                  wr_req_s, discard_s, set_addr_err_s, set_proto_err_s, latch_src_s;
   logic                  fifo_full_s, fifo_empty_s, wr_en_s, pop_s;
   logic [FLIT_WIDTH+1:0] mem_r [FIFO_DEPTH];
   logic [FLIT_WIDTH+1:0] rd_flit_s;
   logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
   logic [AW:0]           count_r;
   logic [CW-1:0]         pend_r, credit_total_s;
   logic                  credit_due_s;
   logic                  credit_r, proto_err_r, ovf_err_r;
   logic [X_W-1:0]        src_x_r;
   logic [Y_W-1:0]        src_y_r;

   assign flit_head_s  = rx.flit_in[FLIT_WIDTH+1];
   assign flit_tail_s  = rx.flit_in[FLIT_WIDTH];
   assign hdr_dest_y_s = rx.flit_in[Y_W-1:0];
   assign hdr_dest_x_s = rx.flit_in[Y_W+X_W-1:Y_W];
   assign hdr_src_y_s  = rx.flit_in[2*Y_W+X_W-1:Y_W+X_W];
   assign hdr_src_x_s  = rx.flit_in[2*Y_W+2*X_W-1:2*Y_W+X_W];
   assign hdr_match_s  = (hdr_dest_x_s == OWN_X) && (hdr_dest_y_s == OWN_Y);

   assign fifo_full_s  = (count_r == FULL_CNT);
   assign fifo_empty_s = (count_r == {(AW+1){1'b0}});
   // A write into a full buffer is lost even if a pop frees a slot this cycle
   assign wr_en_s      = wr_req_s & ~fifo_full_s;
   assign pop_s        = ~fifo_empty_s & rx.pck_ready_in;

   // Classify each incoming flit: buffer, discard, error flags, packet state
   always_comb begin
      next_state_s    = state_r;
      wr_req_s        = 1'b0;
      discard_s       = 1'b0;
      set_addr_err_s  = 1'b0;
      set_proto_err_s = 1'b0;
      latch_src_s     = 1'b0;
      if (rx.flit_wr_in) begin
         if (flit_head_s) begin
            // A head always opens a new packet; inside a packet it is an error
            set_proto_err_s = (state_r != IDLE);
            if (dest_match_s) begin
               wr_req_s     = 1'b1;
               latch_src_s  = 1'b1;
               next_state_s = flit_tail_s ? IDLE : RECV;
            end else begin
               discard_s      = 1'b1;
               set_addr_err_s = 1'b1;
               next_state_s   = flit_tail_s ? IDLE : DROP;
            end
         end else begin
            case (state_r)
               RECV: begin
                  wr_req_s     = 1'b1;
                  next_state_s = flit_tail_s ? IDLE : RECV;
               end
               DROP: begin
                  discard_s    = 1'b1;
                  next_state_s = flit_tail_s ? IDLE : DROP;
               end
               IDLE: begin
                  discard_s       = 1'b1;
                  set_proto_err_s = 1'b1;
                  next_state_s    = IDLE;
               end
               default: begin
                  discard_s       = 1'b1;
                  set_proto_err_s = 1'b1;
                  next_state_s    = IDLE;
               end
            endcase
         end
      end else begin
         next_state_s = state_r;
      end
   end

   // Packet state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= next_state_s;
   end

   // Buffer storage; validity is tracked by count_r so no reset is needed
   always_ff @(posedge clk) begin
      if (wr_en_s) mem_r[wr_ptr_r] <= rx.flit_in;
   end

   // Buffer pointers and occupancy (pointers wrap at the power-of-two depth)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         count_r <= count_r + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
      end
   end

   // Pop and discard can free two slots at once; emit one pulse per cycle
   assign credit_total_s = pend_r + CW'(pop_s) + CW'(discard_s);
   assign credit_due_s   = (credit_total_s != {CW{1'b0}});

   // Credit pulse generation with carry-over of extra credits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit_r <= 1'b0;
         pend_r   <= {CW{1'b0}};
      end else begin
         credit_r <= credit_due_s;
         pend_r   <= credit_total_s - CW'(credit_due_s);
      end
   end

   // Sticky protocol/overflow flags and source address of the current packet
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         proto_err_r <= 1'b0;
         ovf_err_r   <= 1'b0;
         src_x_r     <= {X_W{1'b0}};
         src_y_r     <= {Y_W{1'b0}};
      end else begin
         if (set_proto_err_s)          proto_err_r <= 1'b1;
         if (wr_req_s && fifo_full_s)  ovf_err_r   <= 1'b1;
         if (latch_src_s) begin
            src_x_r <= hdr_src_x_s;
            src_y_r <= hdr_src_y_s;
         end
      end
   end

`ifdef NI_RX_ADDR_CHECK_EN
   logic addr_err_r;
   assign dest_match_s = hdr_match_s;

   // Sticky flag for heads addressed to another node
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               addr_err_r <= 1'b0;
      else if (set_addr_err_s) addr_err_r <= 1'b1;
   end

   assign rx.addr_err_out = addr_err_r;
`else
   logic unused_addr_check_s;
   assign dest_match_s        = 1'b1;
   assign unused_addr_check_s = hdr_match_s | set_addr_err_s;
   assign rx.addr_err_out     = 1'b0;
`endif

   // Output data is forced to zero when nothing is buffered
   assign rd_flit_s         = mem_r[rd_ptr_r];
   assign rx.pck_valid_out  = ~fifo_empty_s;
   assign rx.pck_data_out   = fifo_empty_s ? {FLIT_WIDTH{1'b0}} : rd_flit_s[FLIT_WIDTH-1:0];
   assign rx.pck_sop_out    = ~fifo_empty_s & rd_flit_s[FLIT_WIDTH+1];
   assign rx.pck_eop_out    = ~fifo_empty_s & rd_flit_s[FLIT_WIDTH];
   assign rx.credit_out     = credit_r;
   assign rx.proto_err_out  = proto_err_r;
   assign rx.ovf_err_out    = ovf_err_r;
   assign rx.src_x_out      = src_x_r;
   assign rx.src_y_out      = src_y_r;
endmodule
